// File: rtl/counter_pkg.sv
// Shared types and constants for the up/down modulo counter family.
package counter_pkg;

  typedef enum logic {ST_RUN, ST_HALT} cnt_state_t;

  localparam logic MODE_WRAP    = 1'b0;
  localparam logic MODE_ONESHOT = 1'b1;

endpackage

// File: rtl/counter_updown_mod_if.sv
// Control and status bundle of the up/down modulo counter.
interface counter_updown_mod_if #(
  parameter int unsigned WIDTH = 4
);

  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] din;
  logic             mode;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             wrap;
  logic             done;

  modport master (
    output en, up, load, din, mode,
    input  count, tc, wrap, done
  );

  modport slave (
    input  en, up, load, din, mode,
    output count, tc, wrap, done
  );

endinterface

// File: rtl/counter_next.sv
// Combinational modulo step: next value, terminal count and wrap flag.
module counter_next #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned MODULO = 16
) (
  input  logic [WIDTH-1:0] count,
  input  logic             up,
  output logic [WIDTH-1:0] next,
  output logic             tc,
  output logic             will_wrap
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MODULO - 1);

  // Terminal detect against the modulo bound rather than relying on overflow.
  always_comb begin
    tc        = up ? (count == MAX_V) : (count == '0);
    will_wrap = tc;
    if (up) begin
      next = tc ? '0 : count + WIDTH'(1);
    end else begin
      next = tc ? MAX_V : count - WIDTH'(1);
    end
  end

endmodule

// File: rtl/counter_updown_mod.sv
// Up/down modulo counter with load, enable, wrap or one-shot mode.
module counter_updown_mod
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned MODULO = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  counter_updown_mod_if.slave  bus
);

  localparam longint unsigned SPAN  = 64'(1) << WIDTH;
  localparam int unsigned     WP1   = WIDTH + 1;
  localparam logic [WIDTH:0]  MOD_X = WP1'(MODULO);
  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MODULO - 1);

  // Reject parameter sets that cannot represent MODULO states.
  if (WIDTH < 1 || WIDTH > 63 || MODULO < 2 || 64'(MODULO) > SPAN) begin : g_bad_param
    $error("counter_updown_mod: illegal WIDTH/MODULO combination");
  end

  cnt_state_t       state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] step_val;
  logic             tc;
  logic             will_wrap;
  logic [WIDTH-1:0] load_val;

  counter_next #(
    .WIDTH  (WIDTH),
    .MODULO (MODULO)
  ) u_next (
    .count     (count_q),
    .up        (bus.up),
    .next      (step_val),
    .tc        (tc),
    .will_wrap (will_wrap)
  );

  // Next-state and register inputs; load beats enable, HALT ignores enable.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    wrap_d   = 1'b0;
    done_d   = done_q;
    load_val = ({1'b0, bus.din} >= MOD_X) ? MAX_V : bus.din;

    if (bus.load) begin
      count_d = load_val;
      state_d = ST_RUN;
      done_d  = 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (bus.en) begin
            if (!tc || bus.mode == MODE_WRAP) begin
              count_d = step_val;
              wrap_d  = will_wrap;
            end else begin
              state_d = ST_HALT;
              done_d  = 1'b1;
            end
          end
        end
        ST_HALT: begin
          state_d = ST_HALT;
        end
        default: begin
          state_d = ST_RUN;
        end
      endcase
    end
  end

  // State, count and flag registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
      count_q <= '0;
      wrap_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      wrap_q  <= wrap_d;
      done_q  <= done_d;
    end
  end

  assign bus.count = count_q;
  assign bus.tc    = tc;
  assign bus.wrap  = wrap_q;
  assign bus.done  = done_q;

endmodule

// File: tb/tb_counter_updown_mod.sv
// Bench: three counter configurations driven in lockstep against a behavioural model.
module tb_counter_updown_mod;

  localparam int NDUT = 3;
  localparam int MODS [NDUT] = '{10, 16, 2};
  localparam int WIDS [NDUT] = '{4, 4, 1};

  logic       clk;
  logic       reset;
  logic       en;
  logic       up;
  logic       load;
  logic [3:0] din;
  logic       mode;

  int total;
  int bad;

  counter_updown_mod_if #(.WIDTH(4)) if10 ();
  counter_updown_mod_if #(.WIDTH(4)) if16 ();
  counter_updown_mod_if #(.WIDTH(1)) if2 ();

  assign if10.en = en;  assign if10.up = up;  assign if10.load = load;
  assign if10.din = din; assign if10.mode = mode;
  assign if16.en = en;  assign if16.up = up;  assign if16.load = load;
  assign if16.din = din; assign if16.mode = mode;
  assign if2.en = en;   assign if2.up = up;   assign if2.load = load;
  assign if2.din = din[0]; assign if2.mode = mode;

  counter_updown_mod #(.WIDTH(4), .MODULO(10)) u_dut10 (.clk(clk), .reset(reset), .bus(if10.slave));
  counter_updown_mod #(.WIDTH(4), .MODULO(16)) u_dut16 (.clk(clk), .reset(reset), .bus(if16.slave));
  counter_updown_mod #(.WIDTH(1), .MODULO(2))  u_dut2  (.clk(clk), .reset(reset), .bus(if2.slave));

  logic [3:0] d_cnt  [NDUT];
  logic       d_tc   [NDUT];
  logic       d_wrap [NDUT];
  logic       d_done [NDUT];

  assign d_cnt[0] = if10.count; assign d_tc[0] = if10.tc;
  assign d_wrap[0] = if10.wrap; assign d_done[0] = if10.done;
  assign d_cnt[1] = if16.count; assign d_tc[1] = if16.tc;
  assign d_wrap[1] = if16.wrap; assign d_done[1] = if16.done;
  assign d_cnt[2] = {3'b000, if2.count}; assign d_tc[2] = if2.tc;
  assign d_wrap[2] = if2.wrap; assign d_done[2] = if2.done;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural model: count in 0..MOD-1, halted flag, wrap pulse.
  int m_cnt  [NDUT];
  bit m_halt [NDUT];
  bit m_wrap [NDUT];
  bit m_valid = 1'b0;

  always @(posedge clk) begin
    for (int k = 0; k < NDUT; k++) begin
      int c;
      int lim;
      int dv;
      bit h;
      bit w;
      bit at_end;
      lim = MODS[k];
      c   = m_cnt[k];
      h   = m_halt[k];
      w   = 1'b0;
      dv  = int'(din) % (1 << WIDS[k]);
      if (reset) begin
        c = 0;
        h = 1'b0;
      end else if (load) begin
        c = (dv >= lim) ? lim - 1 : dv;
        h = 1'b0;
      end else if (!h && en) begin
        at_end = up ? (c == lim - 1) : (c == 0);
        if (at_end && mode) begin
          h = 1'b1;
        end else begin
          w = at_end;
          c = (c + (up ? 1 : lim - 1)) % lim;
        end
      end
      m_cnt[k]  <= c;
      m_halt[k] <= h;
      m_wrap[k] <= w;
    end
    if (reset) m_valid <= 1'b1;
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      for (int k = 0; k < NDUT; k++) begin
        int mtc;
        mtc = up ? int'(m_cnt[k] == MODS[k] - 1) : int'(m_cnt[k] == 0);
        check($sformatf("count[m%0d]", MODS[k]), int'(d_cnt[k]), m_cnt[k]);
        check($sformatf("tc[m%0d]", MODS[k]), int'(d_tc[k]), mtc);
        check($sformatf("wrap[m%0d]", MODS[k]), int'(d_wrap[k]), int'(m_wrap[k]));
        check($sformatf("done[m%0d]", MODS[k]), int'(d_done[k]), int'(m_halt[k]));
      end
    end
  end

  // Apply one cycle of inputs; on return, outputs reflect that cycle's edge.
  task automatic drive(input bit r, input bit l, input bit e, input bit u,
                       input bit m, input int d);
    reset = r; load = l; en = e; up = u; mode = m; din = 4'(d);
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1; load = 1'b0; en = 1'b0; up = 1'b1; mode = 1'b0; din = 4'd0;

    drive(1, 0, 0, 1, 0, 0);
    drive(1, 0, 1, 1, 0, 0);
    check("reset_count", int'(if10.count), 0);
    check("reset_wrap", int'(if10.wrap), 0);
    check("reset_done", int'(if10.done), 0);

    // Count up through the MODULO=10 wrap.
    for (int i = 0; i < 9; i++) drive(0, 0, 1, 1, 0, 0);
    check("up_at_9", int'(if10.count), 9);
    check("tc_at_9", int'(if10.tc), 1);
    check("wrap_before", int'(if10.wrap), 0);
    drive(0, 0, 1, 1, 0, 0);
    check("up_wrapped", int'(if10.count), 0);
    check("wrap_pulse", int'(if10.wrap), 1);
    check("m16_at_10", int'(if16.count), 10);
    drive(0, 0, 1, 1, 0, 0);
    check("wrap_single", int'(if10.wrap), 0);
    check("after_wrap", int'(if10.count), 1);

    // Count down from reset.
    drive(1, 0, 0, 0, 0, 0);
    check("down_tc0", int'(if10.tc), 1);
    drive(0, 0, 1, 0, 0, 0);
    check("down_wrap9", int'(if10.count), 9);
    check("down_wrap_pulse", int'(if10.wrap), 1);
    check("m16_down_15", int'(if16.count), 15);
    drive(0, 0, 1, 0, 0, 0);
    check("down_8", int'(if10.count), 8);

    // One-shot: halt at 9, hold through extra enables and mode/up changes.
    drive(1, 0, 0, 1, 1, 0);
    for (int i = 0; i < 9; i++) drive(0, 0, 1, 1, 1, 0);
    check("os_at_9", int'(if10.count), 9);
    check("os_not_done", int'(if10.done), 0);
    drive(0, 0, 1, 1, 1, 0);
    check("os_done", int'(if10.done), 1);
    check("os_hold", int'(if10.count), 9);
    for (int i = 0; i < 5; i++) drive(0, 0, 1, 1, 1, 0);
    drive(0, 0, 1, 0, 0, 0);
    drive(0, 0, 1, 1, 0, 0);
    check("halt_sticky", int'(if10.done), 1);
    check("halt_count", int'(if10.count), 9);
    drive(0, 1, 0, 1, 1, 3);
    check("load3", int'(if10.count), 3);
    check("load_clr_done", int'(if10.done), 0);
    drive(0, 0, 1, 1, 1, 0);
    check("resume", int'(if10.count), 4);

    // Clamp and load-over-enable.
    drive(0, 1, 0, 1, 0, 12);
    check("clamp10", int'(if10.count), 9);
    check("noclamp16", int'(if16.count), 12);
    drive(0, 1, 1, 1, 0, 5);
    check("load_wins", int'(if10.count), 5);
    drive(0, 0, 1, 1, 0, 0);
    check("step_to_6", int'(if10.count), 6);

    // Reset mid-count, with load and en also high.
    drive(1, 1, 1, 1, 0, 7);
    check("rst_mid", int'(if10.count), 0);
    check("rst_mid_done", int'(if10.done), 0);

    // Reset while halted.
    for (int i = 0; i < 11; i++) drive(0, 0, 1, 1, 1, 0);
    check("halt_again", int'(if10.done), 1);
    drive(1, 0, 1, 1, 1, 0);
    check("rst_halt_count", int'(if10.count), 0);
    check("rst_halt_done", int'(if10.done), 0);
    drive(0, 0, 1, 1, 1, 0);
    check("run_after_rst", int'(if10.count), 1);

    // En held, direction toggled every 3 cycles, wrap mode.
    drive(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 36; i++) drive(0, 0, 1, ((i / 3) % 2) == 1, 0, 0);
    drive(0, 0, 0, 1, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
